pkt_req_gen: RTL and testbench
==============================

Name: pkt_req_gen

Overview:
- Requester-side counterpart of the per-output req/gnt arbiters in the router.
- Buffers incoming flits in a small FIFO and decodes the head flit's destination with XY routing.
- Raises exactly one request line toward the selected output arbiter, then streams the packet's flits while that grant is held.
- Drops the request after the tail flit and waits for the grant to fall before starting the next packet.

Parameters:
- FLIT_W, 16: flit width. [FLIT_W-1:FLIT_W-2] is the type field, [7:4] is dest_x, [3:0] is dest_y.
- DEPTH, 4: FIFO depth in flits. Power of two, minimum 2.
- LOC_X, 0: this router's X coordinate (4 bits).
- LOC_Y, 0: this router's Y coordinate (4 bits).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset. Asynchronous, active-high. All state clears immediately on assertion.
- in_flit  in  FLIT_W  upstream flit.
- in_valid  in  1  in_flit is valid this cycle.
- in_ready  out  1  high when the FIFO is not full. A push happens when in_valid && in_ready.
- req  out  5  one-hot request. Bit 0 local, 1 north, 2 east, 3 south, 4 west.
- gnt  in  5  grant from each output arbiter. Registered on the arbiter side, so it arrives one cycle after req.
- out_ready  in  1  downstream can accept a flit.
- out_flit  out  FLIT_W  registered flit toward the crossbar.
- out_valid  out  1  out_flit is valid this cycle.
- drop_err  out  1  one-cycle pulse when a malformed flit is discarded.

Behaviour:
- Flit types:
  - 00 head+tail (single-flit packet)
  - 01 head
  - 10 body
  - 11 tail
- Reset values: req=0, out_valid=0, out_flit=0, drop_err=0, FIFO empty, state=IDLE, route=0.
- in_ready is combinational: it equals !full.
- Push and pop in the same cycle are both performed. When the FIFO is full, no push occurs even if a pop happens that cycle.
- Routing, evaluated in this order:
  - dest_x > LOC_X: east
  - dest_x < LOC_X: west
  - dest_y > LOC_Y: north
  - dest_y < LOC_Y: south
  - otherwise: local
- State machine, 2-bit encoding. req is registered and is high only in REQ and SEND, driving bit route.
  - IDLE:
    - FIFO empty: stay in IDLE.
    - Front flit is type 00 or 01: latch route, go to REQ.
    - Front flit is type 10 or 11: pop and discard it, pulse drop_err, stay in IDLE.
  - REQ: wait for gnt[route]=1, then go to SEND. No timeout.
  - SEND:
    - Pop fires when gnt[route] && out_ready && !empty.
    - On each pop: out_flit <= front flit and out_valid <= 1 on the next edge. Without a pop, out_valid <= 0.
    - Popping a type 00 or 11 flit: go to RELEASE.
    - FIFO underflow mid-packet: stay in SEND with req held and no flits issued.
  - RELEASE: req=0. Stay until gnt[route]=0, then go to IDLE.
    - The grant stays high for one cycle after req falls; no flit may be sent while in RELEASE.
- Timing requirement: req is low for at least one cycle between packets, so the arbiter passes through its idle state.
- Grant loss during SEND (gnt[route] drops): stall with no pop. This is not an error.
- gnt bits other than route are ignored.
- Latency: a head flit at the FIFO front in IDLE appears on out_flit at the earliest 4 cycles later (IDLE→REQ, req visible, gnt back, pop registers).
- Reset asserted mid-packet: all state clears immediately, req and out_valid fall asynchronously, and FIFO contents are lost.

Optional Feature:
- Macro: PKT_REQ_STATS_EN
- When defined, two extra output ports are added:
  - pkt_cnt, 16 bits: increments when a type 00 or 11 flit is popped.
  - flit_cnt, 16 bits: increments on every pop.
- Both counters wrap at 16'hFFFF→0 and clear on rst. Discarded flits are not counted.
- When not defined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package/include:
  - flit type codes FT_HT, FT_HEAD, FT_BODY, FT_TAIL
  - port index constants P_LOCAL..P_WEST
  - dest field bit positions
  - FSM state encodings
- One sub-module: flit_fifo, a synchronous FIFO with parameters FLIT_W and DEPTH and a count-based full/empty.
- Routing is a combinational function inside pkt_req_gen.

Test Plan:
- LOC=(1,1). Push a head with dest (3,1), two bodies and a tail; gnt[2] answers one cycle after req[2].
  → req=00100; four flits out back-to-back; req low one cycle after the tail pops; IDLE entered after gnt[2] falls.
- Single-flit packet, type 00, dest (1,1).
  → req[0] asserted, one flit out, then RELEASE.
- Body flit at the front while in IDLE.
  → flit discarded, drop_err pulses one cycle, req stays 0.
- 3-flit packet sent with out_ready low for 2 cycles mid-packet.
  → out_valid=0 in those cycles, no flit lost, req held.
- Push DEPTH+1 flits with no grant.
  → in_ready=0 after DEPTH pushes; the extra flit is not accepted.
- Assert rst during SEND, then a 2-flit packet to the west.
  → req=0 and out_valid=0 at once; after release req=10000 with normal flow; with PKT_REQ_STATS_EN defined, pkt_cnt=1 and flit_cnt=2.

Source files
------------

// File: rtl/pkt_req_gen_pkg.sv
// pkt_req_gen_pkg
// Shared definitions for the packet requester: flit type codes, output port
// indices, destination field positions and FSM state encodings.
// No ports (package).
package pkt_req_gen_pkg;

  // Flit type field values (top two bits of a flit)
  localparam logic [1:0] FT_HT   = 2'b00;  // single-flit packet
  localparam logic [1:0] FT_HEAD = 2'b01;
  localparam logic [1:0] FT_BODY = 2'b10;
  localparam logic [1:0] FT_TAIL = 2'b11;

  // Output port indices, matching the bit positions of req/gnt
  localparam int P_LOCAL   = 0;
  localparam int P_NORTH   = 1;
  localparam int P_EAST    = 2;
  localparam int P_SOUTH   = 3;
  localparam int P_WEST    = 4;
  localparam int NUM_PORTS = 5;

  // Destination fields inside a flit
  localparam int DEST_W = 4;
  localparam int DX_LSB = 4;
  localparam int DY_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SEND    = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  // A flit of this type opens a packet
  function automatic logic is_head(input logic [1:0] ftype);
    return (ftype == FT_HT) || (ftype == FT_HEAD);
  endfunction

  // A flit of this type closes a packet
  function automatic logic ends_pkt(input logic [1:0] ftype);
    return (ftype == FT_HT) || (ftype == FT_TAIL);
  endfunction

endpackage

// File: rtl/pkt_req_gen_flit_fifo.sv
// flit_fifo
// Synchronous FIFO holding upstream flits. Full/empty derive from an
// occupancy counter. A push is ignored while full even if a pop happens in
// the same cycle; a pop is ignored while empty.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   push_i, data_i push request and flit
//   pop_i          pop request
//   front_o        flit at the head of the FIFO (valid when !empty_o)
//   full_o         occupancy equals DEPTH
//   empty_o        occupancy is zero
module flit_fifo #(
  parameter int FLIT_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [FLIT_W-1:0] data_i,
  input  logic              pop_i,
  output logic [FLIT_W-1:0] front_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [FLIT_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [AW:0]       cnt_q;
  logic              do_push;
  logic              do_pop;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign front_o = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset; emptiness is tracked by the counter
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/pkt_req_gen.sv
// pkt_req_gen
// Requester side of a router output arbiter. Incoming flits are buffered in
// a small FIFO; the head flit's destination is XY-routed to one of five
// outputs, a single request line is raised, and the packet streams out while
// that grant is held. After the tail the request drops and the block waits
// for the grant to fall before taking the next packet, so the arbiter always
// sees at least one idle cycle between packets.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_flit, in_valid     upstream flit and its valid
//   in_ready              FIFO not full (combinational)
//   req[4:0]              one-hot request: local, north, east, south, west
//   gnt[4:0]              registered grants from the output arbiters
//   out_ready             downstream can accept a flit
//   out_flit, out_valid   registered flit toward the crossbar
//   drop_err              one-cycle pulse when a stray body/tail is discarded
// Optional build macro PKT_REQ_STATS_EN adds:
//   pkt_cnt[15:0]         packets sent (type 00/11 flits popped), wrapping
//   flit_cnt[15:0]        flits sent, wrapping
module pkt_req_gen
  import pkt_req_gen_pkg::*;
#(
  parameter int FLIT_W = 16,
  parameter int DEPTH  = 4,
  parameter int LOC_X  = 0,
  parameter int LOC_Y  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] in_flit,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [4:0]        req,
  input  logic [4:0]        gnt,
  input  logic              out_ready,
  output logic [FLIT_W-1:0] out_flit,
  output logic              out_valid,
`ifdef PKT_REQ_STATS_EN
  output logic [15:0]       pkt_cnt,
  output logic [15:0]       flit_cnt,
`endif
  output logic              drop_err
);

  localparam logic [DEST_W-1:0] LX = DEST_W'(LOC_X);
  localparam logic [DEST_W-1:0] LY = DEST_W'(LOC_Y);

  // XY routing: resolve X first, then Y, else deliver locally
  function automatic logic [2:0] route_of(input logic [7:0] dest);
    logic [DEST_W-1:0] dx;
    logic [DEST_W-1:0] dy;
    dx = dest[DX_LSB +: DEST_W];
    dy = dest[DY_LSB +: DEST_W];
    if (dx > LX)      return 3'(P_EAST);
    else if (dx < LX) return 3'(P_WEST);
    else if (dy > LY) return 3'(P_NORTH);
    else if (dy < LY) return 3'(P_SOUTH);
    else              return 3'(P_LOCAL);
  endfunction

  function automatic logic [4:0] port_onehot(input logic [2:0] p);
    logic [4:0] r;
    r    = '0;
    r[p] = 1'b1;
    return r;
  endfunction

  logic [FLIT_W-1:0] front;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic              pop_send;
  logic              pop_drop;
  logic [1:0]        front_type;
  logic              gnt_sel;

  state_e            state_q,    state_d;
  logic [2:0]        route_q,    route_d;
  logic [4:0]        req_q,      req_d;
  logic [FLIT_W-1:0] out_flit_q, out_flit_d;
  logic              out_valid_q, out_valid_d;
  logic              drop_err_q, drop_err_d;

  flit_fifo #(
    .FLIT_W (FLIT_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (in_valid),
    .data_i  (in_flit),
    .pop_i   (fifo_pop),
    .front_o (front),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign in_ready   = !fifo_full;
  assign front_type = front[FLIT_W-1 -: 2];
  assign gnt_sel    = gnt[route_q];

  // A send pop needs the grant, downstream space and a flit; an empty FIFO
  // mid-packet simply stalls with req held.
  assign pop_send = (state_q == ST_SEND) && gnt_sel && out_ready && !fifo_empty;
  // Body/tail at the front while idle cannot belong to any packet: discard.
  assign pop_drop = (state_q == ST_IDLE) && !fifo_empty && !is_head(front_type);
  assign fifo_pop = pop_send || pop_drop;

  always_comb begin
    state_d     = state_q;
    route_d     = route_q;
    req_d       = req_q;
    out_flit_d  = out_flit_q;
    out_valid_d = 1'b0;
    drop_err_d  = pop_drop;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && is_head(front_type)) begin
          route_d = route_of(front[7:0]);
          req_d   = port_onehot(route_d);
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (gnt_sel) state_d = ST_SEND;
      end
      ST_SEND: begin
        if (pop_send) begin
          out_flit_d  = front;
          out_valid_d = 1'b1;
          if (ends_pkt(front_type)) begin
            req_d   = '0;
            state_d = ST_RELEASE;
          end
        end
      end
      ST_RELEASE: begin
        // Grant lags req by a cycle; wait for it to drop before the next packet
        if (!gnt_sel) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      route_q     <= '0;
      req_q       <= '0;
      out_flit_q  <= '0;
      out_valid_q <= 1'b0;
      drop_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      route_q     <= route_d;
      req_q       <= req_d;
      out_flit_q  <= out_flit_d;
      out_valid_q <= out_valid_d;
      drop_err_q  <= drop_err_d;
    end
  end

  assign req       = req_q;
  assign out_flit  = out_flit_q;
  assign out_valid = out_valid_q;
  assign drop_err  = drop_err_q;

`ifdef PKT_REQ_STATS_EN
  logic [15:0] pkt_cnt_q;
  logic [15:0] flit_cnt_q;

  // Only flits actually sent are counted; discarded strays are not
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt_q  <= '0;
      flit_cnt_q <= '0;
    end else if (pop_send) begin
      flit_cnt_q <= flit_cnt_q + 16'd1;
      if (ends_pkt(front_type)) pkt_cnt_q <= pkt_cnt_q + 16'd1;
    end
  end

  assign pkt_cnt  = pkt_cnt_q;
  assign flit_cnt = flit_cnt_q;
`endif

endmodule

// File: tb/tb_pkt_req_gen.sv
module tb_pkt_req_gen;

  localparam int FLIT_W = 16;
  localparam int DEPTH  = 4;
  localparam int LX     = 1;
  localparam int LY     = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [FLIT_W-1:0] in_flit;
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        req;
  logic [4:0]        gnt;
  logic              out_ready;
  logic [FLIT_W-1:0] out_flit;
  logic              out_valid;
  logic              drop_err;
`ifdef PKT_REQ_STATS_EN
  logic [15:0]       pkt_cnt;
  logic [15:0]       flit_cnt;
`endif

  always #5 clk = ~clk;

  pkt_req_gen #(
    .FLIT_W (FLIT_W),
    .DEPTH  (DEPTH),
    .LOC_X  (LX),
    .LOC_Y  (LY)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_flit   (in_flit),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .req       (req),
    .gnt       (gnt),
    .out_ready (out_ready),
    .out_flit  (out_flit),
    .out_valid (out_valid),
`ifdef PKT_REQ_STATS_EN
    .pkt_cnt   (pkt_cnt),
    .flit_cnt  (flit_cnt),
`endif
    .drop_err  (drop_err)
  );

  // Arbiter stand-in: grant is the registered request, optionally withheld
  logic gnt_en;
  always @(posedge clk or posedge rst) begin
    if (rst) gnt <= '0;
    else     gnt <= req & {5{gnt_en}};
  end

  int vectors    = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit          is_drop;
    logic [15:0] flit;
    int          port;
  } ev_t;

  ev_t exp_q[$];
  bit  in_pkt   = 0;
  int  cur_port = 0;

  function automatic int ref_port(input logic [15:0] f);
    int dx, dy;
    dx = int'(f[7:4]);
    dy = int'(f[3:0]);
    if (dx > LX) return 2;
    if (dx < LX) return 4;
    if (dy > LY) return 1;
    if (dy < LY) return 3;
    return 0;
  endfunction

  // Called for every flit the DUT accepted, in arrival order
  function automatic void model_accept(input logic [15:0] f);
    ev_t e;
    logic [1:0] t;
    t = f[15:14];
    e.flit = f;
    e.is_drop = 0;
    if (!in_pkt) begin
      if (t == 2'b10 || t == 2'b11) begin
        e.is_drop = 1;
        e.port = 0;
      end else begin
        cur_port = ref_port(f);
        e.port = cur_port;
        in_pkt = (t == 2'b01);
      end
    end else begin
      e.port = cur_port;
      if (t == 2'b00 || t == 2'b11) in_pkt = 0;
    end
    exp_q.push_back(e);
  endfunction

  function automatic logic [15:0] mk(input logic [1:0] t, input int dx, input int dy, input int pay);
    return {t, 6'(pay), 4'(dx), 4'(dy)};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  logic [4:0] prev_req = '0;
  always @(negedge clk) begin
    ev_t e;
    if (!rst) begin
      if (out_valid) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL out_unexpected: got flit %0h expected none", out_flit);
        end else begin
          e = exp_q.pop_front();
          if (e.is_drop || out_flit !== e.flit || prev_req !== (5'b1 << e.port)) begin
            miscompares++;
            $display("FAIL out_flit: got flit %0h req %b expected flit %0h req %b drop=%0d",
                     out_flit, prev_req, e.flit, 5'b1 << e.port, e.is_drop);
          end
        end
      end
      if (drop_err) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL drop_unexpected: got drop_err 1 expected 0");
        end else begin
          e = exp_q.pop_front();
          if (!e.is_drop) begin
            miscompares++;
            $display("FAIL drop_err: got drop expected flit %0h", e.flit);
          end
        end
      end
      if (req !== prev_req) begin
        vectors++;
        if ((req != 0 && $countones(req) != 1) || (prev_req != 0 && req != 0)) begin
          miscompares++;
          $display("FAIL req_shape: got %b after %b expected one-hot with idle gap", req, prev_req);
        end
      end
    end
    prev_req = req;
  end

  // ---------------- stimulus helpers ----------------
  task automatic try_push(input logic [15:0] f, output bit acc);
    @(negedge clk);
    in_flit  = f;
    in_valid = 1'b1;
    acc      = in_ready;
    @(posedge clk);
    if (acc) model_accept(f);
    #1 in_valid = 1'b0;
  endtask

  task automatic push(input logic [15:0] f);
    bit acc;
    int n;
    n = 0;
    do begin
      try_push(f, acc);
      n++;
    end while (!acc && n < 300);
    if (!acc) chk("push_timeout", 0, 1);
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && req == 0 && gnt == 0) && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (n >= bound) chk("idle_timeout", 32'(exp_q.size()), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_req(output bit ok);
    int n;
    n = 0;
    while (req == 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = (req != 0);
  endtask

  bit rand_on = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (rand_on) begin
        out_ready = ($urandom % 4) != 0;
        gnt_en    = ($urandom % 8) != 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    bit acc;
    bit ok;
    int n;
    int cnt;
    rst = 1'b1; in_flit = '0; in_valid = 1'b0; out_ready = 1'b1; gnt_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(req), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_flit", 32'(out_flit), 0);
    chk("rst_drop_err", 32'(drop_err), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    rst = 1'b0;

    // 4-flit packet east: latency and back-to-back streaming
    push(mk(2'b01, 3, 1, 1));
    fork
      begin
        push(mk(2'b10, 3, 1, 2));
        push(mk(2'b10, 3, 1, 3));
        push(mk(2'b11, 3, 1, 4));
      end
      begin
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 30);
        chk("latency", 32'(n - 1), 4);
        chk("req_east", 32'(req), 32'b00100);
        cnt = 0;
        while (out_valid && cnt < 10) begin cnt++; @(negedge clk); end
        chk("back_to_back", 32'(cnt), 4);
        chk("req_low_after_tail", 32'(req), 0);
      end
    join
    wait_idle(100);

    // single-flit packet to local
    push(mk(2'b00, 1, 1, 5));
    wait_req(ok);
    chk("req_local", 32'(req), 32'b00001);
    wait_idle(100);

    // stray body while idle
    push(mk(2'b10, 2, 2, 6));
    n = 0;
    while (!drop_err && n < 10) begin @(negedge clk); n++; end
    chk("drop_seen", 32'(drop_err), 1);
    chk("drop_req", 32'(req), 0);
    @(negedge clk);
    chk("drop_pulse_len", 32'(drop_err), 0);
    wait_idle(100);

    // downstream backpressure mid-packet
    push(mk(2'b01, 1, 3, 7));
    push(mk(2'b10, 1, 3, 8));
    push(mk(2'b11, 1, 3, 9));
    n = 0;
    while (!out_valid && n < 30) begin @(negedge clk); n++; end
    chk("stall_first_out", 32'(out_valid), 1);
    out_ready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("stall_no_valid", 32'(out_valid), 0);
      chk("stall_req_north", 32'(req), 32'b00010);
    end
    out_ready = 1'b1;
    wait_idle(100);

    // FIFO fill with grant withheld
    gnt_en = 1'b0;
    cnt = 0;
    try_push(mk(2'b01, 3, 1, 10), acc); cnt += int'(acc);
    try_push(mk(2'b10, 3, 1, 11), acc); cnt += int'(acc);
    try_push(mk(2'b10, 3, 1, 12), acc); cnt += int'(acc);
    try_push(mk(2'b10, 3, 1, 13), acc); cnt += int'(acc);
    chk("fill_accepted", 32'(cnt), 4);
    @(negedge clk);
    chk("full_in_ready", 32'(in_ready), 0);
    try_push(mk(2'b11, 3, 1, 14), acc);
    chk("full_refuse", 32'(acc), 0);
    gnt_en = 1'b1;
    push(mk(2'b11, 3, 1, 15));
    wait_idle(100);

    // reset while sending, then a west packet
    push(mk(2'b01, 3, 1, 16));
    push(mk(2'b10, 3, 1, 17));
    push(mk(2'b10, 3, 1, 18));
    n = 0;
    while (!out_valid && n < 30) begin @(negedge clk); n++; end
    chk("pre_rst_valid", 32'(out_valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_req", 32'(req), 0);
    chk("async_rst_valid", 32'(out_valid), 0);
    exp_q.delete();
    in_pkt = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("post_rst_in_ready", 32'(in_ready), 1);
    push(mk(2'b01, 0, 1, 19));
    push(mk(2'b11, 0, 1, 20));
    wait_req(ok);
    chk("req_west", 32'(req), 32'b10000);
    wait_idle(100);
`ifdef PKT_REQ_STATS_EN
    chk("pkt_cnt", 32'(pkt_cnt), 1);
    chk("flit_cnt", 32'(flit_cnt), 2);
`endif

    // randomized traffic
    rand_on = 1;
    for (int k = 0; k < 60; k++) begin
      int len, dx, dy;
      dx = $urandom_range(0, 3);
      dy = $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) begin
        push(mk(($urandom % 2) ? 2'b11 : 2'b10, dx, dy, k));
      end else begin
        len = $urandom_range(1, 4);
        if (len == 1) push(mk(2'b00, dx, dy, k));
        else begin
          push(mk(2'b01, dx, dy, k));
          for (int b = 1; b < len - 1; b++) push(mk(2'b10, dx, dy, k + b));
          push(mk(2'b11, dx, dy, k + len));
        end
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    @(negedge clk);
    rand_on = 0;
    out_ready = 1'b1;
    gnt_en = 1'b1;
    wait_idle(3000);
    chk("drain_empty", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
